i2c_scl_gen: RTL and testbench

I2C_SCL_GEN -- requirements
Module: i2c_scl_gen

---
 rtl/i2c_scl_gen.sv | 130 +++++++++++++
 tb/tb_i2c_scl_gen.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/i2c_scl_gen.sv
// i2c_scl_gen: I2C master SCL bit-period generator with clock-stretch detection.
// Define I2C_STRETCH_TIMEOUT_EN to abort a bit when stretching reaches TIMEOUT cycles.
module i2c_scl_gen #(
    parameter int CNT_W   = 16,
    parameter int TO_W    = 20,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic [CNT_W-1:0] half_period,
    input  logic             scl_in,
    output logic             scl_oe,
    output logic             busy,
    output logic             bit_done,
    output logic             stretching,
    output logic [TO_W-1:0]  stretch_cnt,
    output logic             timeout
);
    typedef enum logic [1:0] {IDLE, LOW, HIGH_WAIT, HIGH} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, h_q, h_d, h_lat;
    logic [TO_W-1:0]  sc_q, sc_d;
    logic             oe_q, oe_d, busy_q, busy_d, done_q, done_d, str_q, str_d;
    logic             last;
`ifdef I2C_STRETCH_TIMEOUT_EN
    logic             to_q, to_d;
`endif

    assign h_lat = (half_period < CNT_W'(2)) ? CNT_W'(2) : half_period;
    assign last  = cnt_q == h_q - CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        h_d     = h_q;
        oe_d    = oe_q;
        sc_d    = sc_q;
        done_d  = 1'b0;
        str_d   = 1'b0;
`ifdef I2C_STRETCH_TIMEOUT_EN
        to_d    = 1'b0;
`endif
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_d = LOW;
                    h_d     = h_lat;
                    cnt_d   = '0;
                    oe_d    = 1'b1;
                    sc_d    = '0;
                end
                LOW: if (last) begin
                    state_d = HIGH_WAIT;
                    oe_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                HIGH_WAIT:
`ifdef I2C_STRETCH_TIMEOUT_EN
                if (!scl_in && sc_q == TO_W'(TIMEOUT - 1)) begin
                    to_d    = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else
`endif
                if (scl_in) begin
                    state_d = HIGH;
                    cnt_d   = CNT_W'(1);
                end else begin
                    str_d = 1'b1;
                    sc_d  = &sc_q ? sc_q : sc_q + TO_W'(1);
                end
                default: if (last) begin
                    // a start on the final high cycle chains straight into the next bit
                    done_d  = 1'b1;
                    state_d = start ? LOW : IDLE;
                    h_d     = start ? h_lat : h_q;
                    cnt_d   = '0;
                    oe_d    = start;
                    sc_d    = start ? '0 : sc_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            endcase
        end
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            h_q     <= CNT_W'(2);
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            str_q   <= 1'b0;
            sc_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            h_q     <= h_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            str_q   <= str_d;
            sc_q    <= sc_d;
        end
    end

`ifdef I2C_STRETCH_TIMEOUT_EN
    always_ff @(posedge clk) to_q <= reset ? 1'b0 : to_d;
    assign timeout = to_q;
`else
    assign timeout = 1'b0;
`endif

    assign scl_oe      = oe_q;
    assign busy        = busy_q;
    assign bit_done    = done_q;
    assign stretching  = str_q;
    assign stretch_cnt = sc_q;
endmodule

// File: tb/tb_i2c_scl_gen.sv
// tb_i2c_scl_gen: directed vector table plus hand sequences for stretch, chaining and aborts.
module tb_i2c_scl_gen;
    logic        clk = 1'b0;
    logic        reset, enable, start, scl_in;
    logic [15:0] half_period;
    logic        scl_oe, busy, bit_done, stretching, timeout;
    logic [19:0] stretch_cnt;

    always #5 clk = ~clk;

    i2c_scl_gen #(.CNT_W(16), .TO_W(20), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .start(start),
        .half_period(half_period), .scl_in(scl_in), .scl_oe(scl_oe),
        .busy(busy), .bit_done(bit_done), .stretching(stretching),
        .stretch_cnt(stretch_cnt), .timeout(timeout)
    );

    typedef struct {
        string       name;
        logic        rst, en, st;
        logic [15:0] hp;
        logic        sin, oe, bsy, done, str;
        logic [19:0] sc;
    } vec_t;

    vec_t vq[$];
    int   applied = 0, miscompares = 0;

    function automatic logic [24:0] obs();
        return {scl_oe, busy, bit_done, stretching, timeout, stretch_cnt};
    endfunction

    task automatic check(input string name, input logic [24:0] exp);
        applied++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL %s: got oe/busy/done/str/to/cnt=%b/%b/%b/%b/%b/%0d want %b/%b/%b/%b/%b/%0d",
                     name, scl_oe, busy, bit_done, stretching, timeout, stretch_cnt,
                     exp[24], exp[23], exp[22], exp[21], exp[20], exp[19:0]);
        end
    endtask

    task automatic step(input logic rst, en, st, input logic [15:0] hp, input logic sin);
        reset = rst; enable = en; start = st; half_period = hp; scl_in = sin;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input string n, input logic rst, en, st, input logic [15:0] hp,
                       input logic sin, oe, bsy, done, str, input logic [19:0] sc);
        vq.push_back('{n, rst, en, st, hp, sin, oe, bsy, done, str, sc});
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; start = 1'b0; half_period = '0; scl_in = 1'b1;
        add("reset_over_start", 1, 1, 1, 4, 1, 0, 0, 0, 0, 0);
        add("h4_e0", 0, 1, 1, 4, 1, 1, 1, 0, 0, 0);
        add("h4_e1", 0, 1, 0, 9, 0, 1, 1, 0, 0, 0);
        add("h4_e2", 0, 1, 0, 9, 0, 1, 1, 0, 0, 0);
        add("h4_e3", 0, 1, 0, 9, 0, 1, 1, 0, 0, 0);
        add("h4_e4", 0, 1, 0, 9, 0, 0, 1, 0, 0, 0);
        add("h4_e5", 0, 1, 0, 9, 1, 0, 1, 0, 0, 0);
        add("h4_e6", 0, 1, 0, 9, 1, 0, 1, 0, 0, 0);
        add("h4_e7", 0, 1, 0, 9, 1, 0, 1, 0, 0, 0);
        add("h4_e8", 0, 1, 0, 9, 1, 0, 0, 1, 0, 0);
        add("h4_e9", 0, 1, 0, 9, 1, 0, 0, 0, 0, 0);
        add("h1_e0", 0, 1, 1, 1, 1, 1, 1, 0, 0, 0);
        add("h1_e1", 0, 1, 0, 1, 0, 1, 1, 0, 0, 0);
        add("h1_e2", 0, 1, 0, 1, 0, 0, 1, 0, 0, 0);
        add("h1_e3", 0, 1, 0, 1, 1, 0, 1, 0, 0, 0);
        add("h1_glitch", 0, 1, 0, 1, 0, 0, 0, 1, 0, 0);
        add("h0_e0", 0, 1, 1, 0, 1, 1, 1, 0, 0, 0);
        add("h0_e1", 0, 1, 0, 0, 0, 1, 1, 0, 0, 0);
        add("h0_e2", 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        add("h0_e3", 0, 1, 0, 0, 1, 0, 1, 0, 0, 0);
        add("h0_e4", 0, 1, 0, 0, 1, 0, 0, 1, 0, 0);
        add("disabled_start", 0, 0, 1, 4, 1, 0, 0, 0, 0, 0);

        foreach (vq[i]) begin
            step(vq[i].rst, vq[i].en, vq[i].st, vq[i].hp, vq[i].sin);
            check(vq[i].name, {vq[i].oe, vq[i].bsy, vq[i].done, vq[i].str, 1'b0, vq[i].sc});
        end

        // slave stretches the high phase for 10 cycles
        step(0, 1, 1, 4, 1);
        repeat (4) step(0, 1, 0, 4, 0);
        check("stretch_release", {5'b01000, 20'd0});
        for (int k = 1; k <= 10; k++) begin
            step(0, 1, 0, 4, 0);
            check($sformatf("stretch_%0d", k), {5'b01010, 20'(k)});
        end
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 0, 4, 1);
            check($sformatf("stretch_high_%0d", k), {5'b01000, 20'd10});
        end
        step(0, 1, 0, 4, 1);
        check("stretch_done", {5'b00100, 20'd10});
        step(0, 1, 0, 4, 1);
        check("stretch_idle", {5'b00000, 20'd10});

        // back-to-back bits, H=3, slave follows the master
        for (int k = 0; k <= 18; k++) begin
            step(0, 1, 1, 3, !scl_oe);
            check($sformatf("b2b_%0d", k),
                  {(k % 6) < 3, 1'b1, k > 0 && k % 6 == 0, 2'b00, 20'd0});
        end
        step(0, 0, 0, 3, 1);
        check("b2b_disable", {5'b00000, 20'd0});

        // SCL stuck low after release
        step(0, 1, 1, 2, 1);
        step(0, 1, 0, 2, 0);
        step(0, 1, 0, 2, 0);
`ifdef I2C_STRETCH_TIMEOUT_EN
        repeat (7) step(0, 1, 0, 2, 0);
        check("stuck_cnt7", {5'b01010, 20'd7});
        step(0, 1, 0, 2, 0);
        check("stuck_timeout", {5'b00001, 20'd7});
        step(0, 1, 0, 2, 0);
        check("stuck_idle", {5'b00000, 20'd7});
`else
        repeat (40) step(0, 1, 0, 2, 0);
        check("stuck_climb", {5'b01010, 20'd40});
        step(0, 0, 0, 2, 0);
        check("stuck_disable", {5'b00000, 20'd40});
`endif

        // reset in the low phase
        step(0, 1, 1, 4, 1);
        step(0, 1, 0, 4, 0);
        step(0, 1, 0, 4, 0);
        step(1, 1, 0, 4, 0);
        check("rst_low", {5'b00000, 20'd0});
        for (int k = 0; k < 6; k++) begin
            step(0, 1, 0, 4, 1);
            check($sformatf("rst_after_%0d", k), {5'b00000, 20'd0});
        end

        // enable drop in the low phase
        step(0, 1, 1, 4, 1);
        step(0, 1, 0, 4, 0);
        step(0, 0, 0, 4, 0);
        check("en_low", {5'b00000, 20'd0});
        for (int k = 0; k < 6; k++) begin
            step(0, 1, 0, 4, 1);
            check($sformatf("en_after_%0d", k), {5'b00000, 20'd0});
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
